wb_spi_sram: RTL and testbench
==============================

# wb_spi_sram

Wishbone slave that serves byte reads and writes from the Levenshtein controller's master port. It translates each access into one serial SRAM transaction: an SPI mode 0 frame with a 23LC1024-style command, a 24-bit address, and one data byte. It sits between the controller's wbm bus and the external SPI SRAM that holds the dictionary and the bitvector tables.

## Interface
Parameters:
- ADDR_WIDTH, 24, Wishbone address width (≤ 24). The address is zero-extended to 24 bits in the SPI frame.

Ports:
- clk_i  in  1  system clock; one clock for the whole block.
- rst_ni  in  1  reset; asynchronous, active-low.
- wbs_cyc_i  in  1  Wishbone cycle.
- wbs_stb_i  in  1  Wishbone strobe.
- wbs_adr_i  in  ADDR_WIDTH  byte address.
- wbs_we_i  in  1  1 = write, 0 = read.
- wbs_dat_i  in  8  write data.
- wbs_ack_o  out  1  one-cycle acknowledge.
- wbs_err_o  out  1  tied 0.
- wbs_rty_o  out  1  tied 0.
- wbs_dat_o  out  8  last byte read.
- spi_cs_n_o  out  1  SRAM chip select, active-low.
- spi_sck_o  out  1  SPI clock, clk_i/2 while shifting.
- spi_mosi_o  out  1  serial data to the SRAM.
- spi_miso_i  in  1  serial data from the SRAM.

## Operation
- States:
  - IDLE → SHIFT → ACK → IDLE.
  - Any state → IDLE on abort.
- IDLE:
  - A request is accepted when cyc & stb & !ack.
  - On acceptance, the block loads a 40-bit frame: {opcode, 24'(adr), we ? dat_i : 8'h00}.
  - Opcodes: READ = 8'h03, WRITE = 8'h02.
  - The block also clears the bit counter (0..39) and the phase bit.
- SHIFT:
  - Frame is sent MSB first. Each bit takes two clk_i cycles.
  - Phase 0: sck = 0, mosi = current frame MSB.
  - Phase 1: sck = 1.
  - At the end of phase 1, miso is shifted into the frame LSB and the frame shifts left.
  - After bit 39, phase 1 completes and the state moves to ACK.
- ACK:
  - cs_n = 1, sck = 0, ack = 1 for exactly one cycle.
  - On a read, wbs_dat_o is loaded with the low 8 bits of the shifted frame, i.e. the last 8 miso bits.
  - On a write, wbs_dat_o is unchanged.
- wbs_dat_o holds its value until the next completed read.
- Abort: if cyc_i is low at any SHIFT edge, the next state is IDLE.
  - cs_n = 1, sck = 0, no ack, wbs_dat_o unchanged.
  - The SRAM sees a truncated frame and ignores it.
- Request fields are sampled only at acceptance. Changes to adr, we or dat_i during SHIFT are ignored.
- wbs_err_o and wbs_rty_o are always 0.

## Timing
- Reset values: wbs_ack_o = 0, wbs_dat_o = 8'h00, spi_cs_n_o = 1, spi_sck_o = 0, spi_mosi_o = 0. State is IDLE and the frame is 0.
- Reset mid-transfer: all outputs go to their reset values immediately and asynchronously. No ack.
- All outputs are registered; there are no combinational paths from inputs to outputs.
- Acceptance edge E0: from E0, cs_n = 0, sck = 0, mosi = bit 39 (opcode MSB).
- SHIFT spans edges E0..E80, giving exactly 40 sck rising edges.
- ack is high in the cycle after E80, i.e. 81 cycles after the request was first sampled.
- ack drops at E81, so a continuously asserted stb is re-accepted at E82 at the earliest.
- Guaranteed cs_n high time between frames: ≥ 2 clk_i cycles.
- Throughput: one byte per 82 clk_i cycles. SCK frequency = clk_i/2, so clk_i must not exceed 2 × the SRAM's SPI maximum.

## Structure
- Package wb_spi_sram_pkg contains:
  - opcode constants SPI_OP_READ = 8'h03, SPI_OP_WRITE = 8'h02;
  - FRAME_BITS = 40;
  - the state enum {IDLE, SHIFT, ACK}.
- One sub-module, spi_frame_shifter, owns the 40-bit shift register, the 6-bit bit counter, the phase bit and the sck/mosi registers.
  - Inputs: load, frame, abort.
  - Outputs: done pulse and received byte.
- The top level owns the Wishbone FSM, ack and wbs_dat_o.

## Test plan
- Read adr 0x000123 with an SRAM model returning 0xA5:
  - mosi carries 0x03, 0x000123, then 8 zero bits.
  - Exactly 40 sck rises are seen.
  - ack is high for one cycle, 81 cycles after acceptance, with wbs_dat_o = 0xA5.
- Write 0x5A to adr 0x800010:
  - mosi carries 0x02, 0x800010, 0x5A.
  - Model memory[0x800010] = 0x5A.
  - ack is high for one cycle and wbs_dat_o still holds 0xA5.
- Back-to-back reads of adr 0x10, then 0x11, with stb held high:
  - The second acceptance happens at E82.
  - cs_n is high for ≥ 2 cycles between frames.
  - Both returned bytes match the model.
- Drop cyc_i after 20 sck rises:
  - cs_n goes high and sck goes low the next cycle.
  - No ack is produced.
  - The next read returns correct data.
- Assert rst_ni low mid-frame:
  - cs_n = 1, sck = 0, mosi = 0 and wbs_dat_o = 0x00 immediately, with no ack.
  - After release, a read of 0x000000 succeeds.

Source files
------------

// File: rtl/wb_spi_sram_pkg.sv
// Shared constants and types for the Wishbone-to-serial-SRAM bridge.
// The frame is opcode, 24-bit address, then one data byte.
package wb_spi_sram_pkg;

    localparam logic [7:0] SPI_OP_READ  = 8'h03;
    localparam logic [7:0] SPI_OP_WRITE = 8'h02;
    localparam int         FRAME_BITS   = 40;

    typedef enum logic [1:0] {
        IDLE,
        SHIFT,
        ACK
    } state_e;

    function automatic logic [FRAME_BITS-1:0] build_frame(
        input logic        we,
        input logic [23:0] adr,
        input logic [7:0]  dat
    );
        return {we ? SPI_OP_WRITE : SPI_OP_READ, adr, we ? dat : 8'h00};
    endfunction

endpackage

// File: rtl/wb_spi_sram_shifter.sv
// SPI mode 0 frame engine: two clk_i cycles per bit, MSB first,
// MISO captured into the LSB on the edge that drops SCK.
module spi_frame_shifter
    import wb_spi_sram_pkg::*;
(
    input  logic                  clk_i,
    input  logic                  rst_ni,
    input  logic                  load,
    input  logic [FRAME_BITS-1:0] frame,
    input  logic                  abort,
    input  logic                  miso,
    output logic                  done,
    output logic [7:0]            rx_byte,
    output logic                  sck,
    output logic                  mosi
);

    logic [FRAME_BITS-1:0] sr_q;
    logic [5:0]            cnt_q;
    logic                  phase_q;
    logic                  busy_q;
    logic                  sck_q;
    logic                  mosi_q;
    logic                  last_bit;

    assign last_bit = (cnt_q == 6'(FRAME_BITS - 1));
    assign done     = busy_q & phase_q & last_bit;
    // Byte as it will be after the final shift, so the top can latch it on time.
    assign rx_byte  = {sr_q[6:0], miso};
    assign sck      = sck_q;
    assign mosi     = mosi_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            sr_q    <= '0;
            cnt_q   <= '0;
            phase_q <= 1'b0;
            busy_q  <= 1'b0;
            sck_q   <= 1'b0;
            mosi_q  <= 1'b0;
        end else if (abort) begin
            cnt_q   <= '0;
            phase_q <= 1'b0;
            busy_q  <= 1'b0;
            sck_q   <= 1'b0;
            mosi_q  <= 1'b0;
        end else if (load) begin
            sr_q    <= frame;
            cnt_q   <= '0;
            phase_q <= 1'b0;
            busy_q  <= 1'b1;
            sck_q   <= 1'b0;
            mosi_q  <= frame[FRAME_BITS-1];
        end else if (busy_q) begin
            if (!phase_q) begin
                phase_q <= 1'b1;
                sck_q   <= 1'b1;
                mosi_q  <= sr_q[FRAME_BITS-1];
            end else begin
                sr_q    <= {sr_q[FRAME_BITS-2:0], miso};
                phase_q <= 1'b0;
                sck_q   <= 1'b0;
                if (last_bit) begin
                    busy_q <= 1'b0;
                    mosi_q <= 1'b0;
                end else begin
                    cnt_q  <= cnt_q + 6'd1;
                    mosi_q <= sr_q[FRAME_BITS-2];
                end
            end
        end
    end

endmodule

// File: rtl/wb_spi_sram.sv
// Wishbone byte slave backed by a 23LC1024-style serial SRAM;
// every access becomes one 40-bit SPI frame.
module wb_spi_sram
    import wb_spi_sram_pkg::*;
#(
    parameter int ADDR_WIDTH = 24
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    input  logic                  wbs_cyc_i,
    input  logic                  wbs_stb_i,
    input  logic [ADDR_WIDTH-1:0] wbs_adr_i,
    input  logic                  wbs_we_i,
    input  logic [7:0]            wbs_dat_i,
    output logic                  wbs_ack_o,
    output logic                  wbs_err_o,
    output logic                  wbs_rty_o,
    output logic [7:0]            wbs_dat_o,
    output logic                  spi_cs_n_o,
    output logic                  spi_sck_o,
    output logic                  spi_mosi_o,
    input  logic                  spi_miso_i
);

    state_e                state_q, state_d;
    logic                  ack_q;
    logic                  cs_n_q;
    logic                  we_q;
    logic [7:0]            dat_q;
    logic                  accept;
    logic                  load;
    logic                  abort;
    logic                  done;
    logic [7:0]            rx_byte;
    logic [FRAME_BITS-1:0] frame;

    assign accept = wbs_cyc_i & wbs_stb_i & ~ack_q;
    assign frame  = build_frame(wbs_we_i, 24'(wbs_adr_i), wbs_dat_i);

    always_comb begin
        state_d = state_q;
        load    = 1'b0;
        abort   = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (accept) begin
                    state_d = SHIFT;
                    load    = 1'b1;
                end
            end
            SHIFT: begin
                if (!wbs_cyc_i) begin
                    state_d = IDLE;
                    abort   = 1'b1;
                end else if (done) begin
                    state_d = ACK;
                end
            end
            ACK:     state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= IDLE;
            ack_q   <= 1'b0;
            cs_n_q  <= 1'b1;
            we_q    <= 1'b0;
            dat_q   <= 8'h00;
        end else begin
            state_q <= state_d;
            ack_q   <= (state_d == ACK);
            cs_n_q  <= (state_d != SHIFT);
            if (load) begin
                we_q <= wbs_we_i;
            end
            if (state_q == SHIFT && state_d == ACK && !we_q) begin
                dat_q <= rx_byte;
            end
        end
    end

    spi_frame_shifter u_shifter (
        .clk_i   (clk_i),
        .rst_ni  (rst_ni),
        .load    (load),
        .frame   (frame),
        .abort   (abort),
        .miso    (spi_miso_i),
        .done    (done),
        .rx_byte (rx_byte),
        .sck     (spi_sck_o),
        .mosi    (spi_mosi_o)
    );

    assign wbs_ack_o  = ack_q;
    assign wbs_err_o  = 1'b0;
    assign wbs_rty_o  = 1'b0;
    assign wbs_dat_o  = dat_q;
    assign spi_cs_n_o = cs_n_q;

endmodule

// File: tb/tb_wb_spi_sram.sv
// Bench for wb_spi_sram: behavioural SPI SRAM plus a scoreboard of
// expected memory contents, randomized and directed accesses.
module tb_wb_spi_sram;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        cyc = 1'b0;
    logic        stb = 1'b0;
    logic        we = 1'b0;
    logic [23:0] adr = '0;
    logic [7:0]  dat_i = '0;
    logic        miso = 1'b0;
    logic        ack, err, rty, cs_n, sck, mosi;
    logic [7:0]  dat_o;

    int checks = 0;
    int failures = 0;

    logic [7:0]  sram    [logic [23:0]];
    logic [7:0]  exp_mem [logic [23:0]];
    logic [39:0] frm = '0;
    int          bits = 0;
    logic [7:0]  rdb = '0;
    logic [7:0]  exp_dat = 8'h00;

    always #5 clk = ~clk;

    wb_spi_sram #(.ADDR_WIDTH(24)) dut (
        .clk_i      (clk),
        .rst_ni     (rst_n),
        .wbs_cyc_i  (cyc),
        .wbs_stb_i  (stb),
        .wbs_adr_i  (adr),
        .wbs_we_i   (we),
        .wbs_dat_i  (dat_i),
        .wbs_ack_o  (ack),
        .wbs_err_o  (err),
        .wbs_rty_o  (rty),
        .wbs_dat_o  (dat_o),
        .spi_cs_n_o (cs_n),
        .spi_sck_o  (sck),
        .spi_mosi_o (mosi),
        .spi_miso_i (miso)
    );

    function automatic logic [7:0] dflt(input logic [23:0] a);
        return a[7:0] ^ a[15:8] ^ 8'h3c;
    endfunction

    function automatic logic [7:0] sram_rd(input logic [23:0] a);
        return sram.exists(a) ? sram[a] : dflt(a);
    endfunction

    function automatic logic [7:0] exp_rd(input logic [23:0] a);
        return exp_mem.exists(a) ? exp_mem[a] : dflt(a);
    endfunction

    // SRAM model: command/address/data captured on SCK rise, read data on SCK fall
    always @(negedge cs_n) begin
        bits = 0;
        frm  = '0;
    end

    always @(posedge sck) begin
        if (!cs_n && bits < 40) begin
            frm  = {frm[38:0], mosi};
            bits = bits + 1;
            if (bits == 40 && frm[39:32] == 8'h02) sram[frm[31:8]] = frm[7:0];
        end
    end

    always @(negedge sck) begin
        if (!cs_n) begin
            if (bits == 32 && frm[31:24] == 8'h03) rdb = sram_rd(frm[23:0]);
            if (bits >= 32 && bits < 40) miso = rdb[39 - bits];
        end
    end

    task automatic wb_xfer(input logic w, input logic [23:0] a,
                           input logic [7:0] d, output int lat,
                           output logic [7:0] rd, output logic ack2);
        cyc = 1'b1; stb = 1'b1; we = w; adr = a; dat_i = d;
        lat = 0;
        while (lat < 200) begin
            @(posedge clk); #1;
            lat++;
            if (ack) break;
        end
        rd = dat_o;
        cyc = 1'b0; stb = 1'b0;
        dat_i = ~d; adr = ~a;
        @(posedge clk); #1;
        ack2 = ack;
    endtask

    task automatic test_reset();
        repeat (3) @(posedge clk);
        #1;
        checks++; if (ack !== 1'b0) begin failures++; $display("FAIL rst_ack got=%b exp=0", ack); end
        checks++; if (dat_o !== 8'h00) begin failures++; $display("FAIL rst_dat got=%h exp=00", dat_o); end
        checks++; if (cs_n !== 1'b1) begin failures++; $display("FAIL rst_cs_n got=%b exp=1", cs_n); end
        checks++; if (sck !== 1'b0) begin failures++; $display("FAIL rst_sck got=%b exp=0", sck); end
        checks++; if (mosi !== 1'b0) begin failures++; $display("FAIL rst_mosi got=%b exp=0", mosi); end
        checks++; if ({err, rty} !== 2'b00) begin failures++; $display("FAIL rst_err_rty got=%b exp=00", {err, rty}); end
        rst_n = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        checks++; if (cs_n !== 1'b1) begin failures++; $display("FAIL idle_cs_n got=%b exp=1", cs_n); end
    endtask

    task automatic test_read();
        int lat; logic [7:0] rd; logic a2;
        sram[24'h000123] = 8'hA5;
        exp_mem[24'h000123] = 8'hA5;
        wb_xfer(1'b0, 24'h000123, 8'h77, lat, rd, a2);
        exp_dat = exp_rd(24'h000123);
        checks++; if (lat !== 81) begin failures++; $display("FAIL read_lat got=%0d exp=81", lat); end
        checks++; if (rd !== exp_dat) begin failures++; $display("FAIL read_data got=%h exp=%h", rd, exp_dat); end
        checks++; if (a2 !== 1'b0) begin failures++; $display("FAIL read_ack_width got=%b exp=0", a2); end
        checks++; if (bits !== 40) begin failures++; $display("FAIL read_sck_rises got=%0d exp=40", bits); end
        checks++; if (frm !== {8'h03, 24'h000123, 8'h00}) begin
            failures++; $display("FAIL read_frame got=%h exp=%h", frm, {8'h03, 24'h000123, 8'h00});
        end
    endtask

    task automatic test_write();
        int lat; logic [7:0] rd; logic a2;
        wb_xfer(1'b1, 24'h800010, 8'h5A, lat, rd, a2);
        exp_mem[24'h800010] = 8'h5A;
        checks++; if (lat !== 81) begin failures++; $display("FAIL write_lat got=%0d exp=81", lat); end
        checks++; if (rd !== exp_dat) begin failures++; $display("FAIL write_dat_hold got=%h exp=%h", rd, exp_dat); end
        checks++; if (a2 !== 1'b0) begin failures++; $display("FAIL write_ack_width got=%b exp=0", a2); end
        checks++; if (frm !== {8'h02, 24'h800010, 8'h5A}) begin
            failures++; $display("FAIL write_frame got=%h exp=%h", frm, {8'h02, 24'h800010, 8'h5A});
        end
        checks++; if (sram_rd(24'h800010) !== 8'h5A) begin
            failures++; $display("FAIL write_mem got=%h exp=5a", sram_rd(24'h800010));
        end
    endtask

    task automatic test_back_to_back();
        int n; int gap; int hi;
        cyc = 1'b1; stb = 1'b1; we = 1'b0; adr = 24'h000010;
        n = 0;
        while (n < 200) begin
            @(posedge clk); #1; n++;
            if (ack) break;
        end
        exp_dat = exp_rd(24'h000010);
        checks++; if (n !== 81) begin failures++; $display("FAIL b2b_lat1 got=%0d exp=81", n); end
        checks++; if (dat_o !== exp_dat) begin failures++; $display("FAIL b2b_data1 got=%h exp=%h", dat_o, exp_dat); end
        adr = 24'h000011;
        hi = cs_n ? 1 : 0;
        gap = 0;
        while (gap < 10) begin
            @(posedge clk); #1; gap++;
            if (!cs_n) break;
            hi++;
        end
        checks++; if (gap !== 2) begin failures++; $display("FAIL b2b_accept got=%0d exp=2", gap); end
        checks++; if (hi < 2) begin failures++; $display("FAIL b2b_cs_gap got=%0d exp>=2", hi); end
        n = 1;
        while (n < 200) begin
            @(posedge clk); #1; n++;
            if (ack) break;
        end
        exp_dat = exp_rd(24'h000011);
        checks++; if (n !== 81) begin failures++; $display("FAIL b2b_lat2 got=%0d exp=81", n); end
        checks++; if (dat_o !== exp_dat) begin failures++; $display("FAIL b2b_data2 got=%h exp=%h", dat_o, exp_dat); end
        checks++; if (frm !== {8'h03, 24'h000011, 8'h00}) begin
            failures++; $display("FAIL b2b_frame got=%h exp=%h", frm, {8'h03, 24'h000011, 8'h00});
        end
        cyc = 1'b0; stb = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic test_abort();
        int rises; int n; int acks; logic prev;
        int lat; logic [7:0] rd; logic a2;
        cyc = 1'b1; stb = 1'b1; we = 1'b1; adr = 24'h000200; dat_i = 8'hC3;
        rises = 0; n = 0; prev = 1'b0;
        while (rises < 20 && n < 200) begin
            @(posedge clk); #1; n++;
            if (sck && !prev) rises++;
            prev = sck;
        end
        checks++; if (rises !== 20) begin failures++; $display("FAIL abort_rises got=%0d exp=20", rises); end
        cyc = 1'b0; stb = 1'b0;
        @(posedge clk); #1;
        checks++; if (cs_n !== 1'b1) begin failures++; $display("FAIL abort_cs_n got=%b exp=1", cs_n); end
        checks++; if (sck !== 1'b0) begin failures++; $display("FAIL abort_sck got=%b exp=0", sck); end
        acks = 0;
        repeat (100) begin
            @(posedge clk); #1;
            if (ack) acks++;
        end
        checks++; if (acks !== 0) begin failures++; $display("FAIL abort_no_ack got=%0d exp=0", acks); end
        checks++; if (bits !== 20) begin failures++; $display("FAIL abort_trunc got=%0d exp=20", bits); end
        checks++; if (dat_o !== exp_dat) begin failures++; $display("FAIL abort_dat_hold got=%h exp=%h", dat_o, exp_dat); end
        wb_xfer(1'b0, 24'h000200, 8'h00, lat, rd, a2);
        exp_dat = exp_rd(24'h000200);
        checks++; if (lat !== 81) begin failures++; $display("FAIL abort_next_lat got=%0d exp=81", lat); end
        checks++; if (rd !== exp_dat) begin failures++; $display("FAIL abort_next_data got=%h exp=%h", rd, exp_dat); end
    endtask

    task automatic test_random();
        int lat; logic [7:0] rd; logic a2;
        logic w; logic [23:0] a; logic [7:0] d; logic [39:0] ef;
        for (int i = 0; i < 10; i++) begin
            w = (i % 4 == 3) ? 1'b0 : 1'($urandom_range(0, 1));
            a = 24'h000100 + 24'($urandom_range(0, 3));
            d = 8'($urandom);
            ef = {w ? 8'h02 : 8'h03, a, w ? d : 8'h00};
            wb_xfer(w, a, d, lat, rd, a2);
            if (w) exp_mem[a] = d;
            else exp_dat = exp_rd(a);
            checks++; if (lat !== 81) begin failures++; $display("FAIL rnd_lat[%0d] got=%0d exp=81", i, lat); end
            checks++; if (frm !== ef) begin failures++; $display("FAIL rnd_frame[%0d] got=%h exp=%h", i, frm, ef); end
            checks++; if (rd !== exp_dat) begin failures++; $display("FAIL rnd_data[%0d] got=%h exp=%h", i, rd, exp_dat); end
        end
    endtask

    task automatic test_reset_mid();
        int rises; int n; logic prev;
        int lat; logic [7:0] rd; logic a2;
        cyc = 1'b1; stb = 1'b1; we = 1'b0; adr = 24'h000055;
        rises = 0; n = 0; prev = 1'b0;
        while (!(rises >= 10 && sck) && n < 200) begin
            @(posedge clk); #1; n++;
            if (sck && !prev) rises++;
            prev = sck;
        end
        #2;
        rst_n = 1'b0;
        #1;
        exp_dat = 8'h00;
        checks++; if (cs_n !== 1'b1) begin failures++; $display("FAIL rstmid_cs_n got=%b exp=1", cs_n); end
        checks++; if (sck !== 1'b0) begin failures++; $display("FAIL rstmid_sck got=%b exp=0", sck); end
        checks++; if (mosi !== 1'b0) begin failures++; $display("FAIL rstmid_mosi got=%b exp=0", mosi); end
        checks++; if (dat_o !== 8'h00) begin failures++; $display("FAIL rstmid_dat got=%h exp=00", dat_o); end
        checks++; if (ack !== 1'b0) begin failures++; $display("FAIL rstmid_ack got=%b exp=0", ack); end
        cyc = 1'b0; stb = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;
        wb_xfer(1'b0, 24'h000000, 8'h00, lat, rd, a2);
        exp_dat = exp_rd(24'h000000);
        checks++; if (lat !== 81) begin failures++; $display("FAIL rstmid_next_lat got=%0d exp=81", lat); end
        checks++; if (rd !== exp_dat) begin failures++; $display("FAIL rstmid_next_data got=%h exp=%h", rd, exp_dat); end
    endtask

    initial begin
        test_reset();
        test_read();
        test_write();
        test_back_to_back();
        test_abort();
        test_random();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
